// File: rtl/pp_pipeline_accel_normalize_stage_if.sv
// FIFO-side stream bundle for the normalize stage: read side of the upstream FIFO
// and write side of the downstream FIFO.
interface pp_pipeline_accel_normalize_stage_if;
  logic        in_empty_n;
  logic        in_read;
  logic [31:0] in_dout;
  logic        out_full_n;
  logic        out_write;
  logic [31:0] out_din;

  modport master (
    input  in_empty_n,
    input  in_dout,
    input  out_full_n,
    output in_read,
    output out_write,
    output out_din
  );

  modport slave (
    output in_empty_n,
    output in_dout,
    output out_full_n,
    input  in_read,
    input  out_write,
    input  out_din
  );
endinterface

// File: rtl/pp_pipeline_accel_normalize_stage.sv
// Per-channel (x - alpha) * beta, rounding shift and int8 saturation, streamed
// FIFO-to-FIFO under ap_ctrl_hs control through a 3-stage pipeline that stalls as a unit.
module pp_pipeline_accel_normalize_stage #(
  parameter int SHIFT = 7,
  parameter int DIM_W = 16
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             ap_start,
  output logic             ap_done,
  output logic             ap_idle,
  output logic             ap_ready,
  input  logic [DIM_W-1:0] rows,
  input  logic [DIM_W-1:0] cols,
  input  logic [23:0]      alpha,
  input  logic [23:0]      beta,
  pp_pipeline_accel_normalize_stage_if.master strm
);

  localparam int CNT_W = 2 * DIM_W;
  localparam logic signed [17:0] ROUND_BIAS = 18'(2 ** (SHIFT - 1));

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e            state_q, state_d;
  logic              ap_done_q, ap_done_d;
  logic              ap_idle_q, ap_idle_d;
  logic [23:0]       alpha_q, alpha_d;
  logic [23:0]       beta_q, beta_d;
  logic [CNT_W-1:0]  rd_left_q, rd_left_d;
  logic [CNT_W-1:0]  wr_left_q, wr_left_d;
  logic              v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [2:0][8:0]   diff_q, diff_d;
  logic [2:0][16:0]  prod_q, prod_d;
  logic [31:0]       out_q, out_d;

  logic              adv;
  logic              rd_en;
  logic              wr_en;
  logic [CNT_W-1:0]  frame_len;
  logic              unused_byte3;

  function automatic logic signed [8:0] diff9(input logic [7:0] x, input logic [7:0] a);
    return $signed({1'b0, x} - {1'b0, a});
  endfunction

  function automatic logic signed [16:0] mul17(input logic signed [8:0] d, input logic [7:0] b);
    logic signed [16:0] dx;
    logic signed [16:0] bx;
    dx = 17'(d);
    bx = $signed({9'b0, b});
    return dx * bx;
  endfunction

  // Round half up via bias, then arithmetic shift floors toward -inf.
  function automatic logic [7:0] round_sat(input logic signed [16:0] p);
    logic signed [17:0] r;
    r = (18'(p) + ROUND_BIAS) >>> SHIFT;
    if (r > 18'sd127) begin
      return 8'h7f;
    end else if (r < -18'sd128) begin
      return 8'h80;
    end else begin
      return r[7:0];
    end
  endfunction

  assign frame_len = CNT_W'(rows) * CNT_W'(cols);
  assign adv       = !v3_q || strm.out_full_n;
  assign rd_en     = (state_q == RUN) && strm.in_empty_n && adv && (rd_left_q != '0);
  assign wr_en     = v3_q && strm.out_full_n;

  assign strm.in_read   = rd_en;
  assign strm.out_write = wr_en;
  assign strm.out_din   = out_q;
  assign ap_done        = ap_done_q;
  assign ap_ready       = ap_done_q;
  assign ap_idle        = ap_idle_q;
  assign unused_byte3   = ^strm.in_dout[31:24];

  always_comb begin
    state_d   = state_q;
    alpha_d   = alpha_q;
    beta_d    = beta_q;
    rd_left_d = rd_left_q;
    wr_left_d = wr_left_q;
    v1_d      = v1_q;
    v2_d      = v2_q;
    v3_d      = v3_q;
    diff_d    = diff_q;
    prod_d    = prod_q;
    out_d     = out_q;

    case (state_q)
      IDLE: begin
        if (ap_start) begin
          alpha_d   = alpha;
          beta_d    = beta;
          rd_left_d = frame_len;
          wr_left_d = frame_len;
          state_d   = (frame_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (rd_en) begin
          rd_left_d = rd_left_q - CNT_W'(1);
        end
        if (wr_en) begin
          wr_left_d = wr_left_q - CNT_W'(1);
          if (wr_left_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Data registers only load behind a valid token so out_din holds across bubbles.
    if (adv) begin
      v1_d = rd_en;
      v2_d = v1_q;
      v3_d = v2_q;
      for (int c = 0; c < 3; c++) begin
        if (rd_en) diff_d[c] = diff9(strm.in_dout[8*c +: 8], alpha_q[8*c +: 8]);
        if (v1_q)  prod_d[c] = mul17(diff_q[c], beta_q[8*c +: 8]);
        if (v2_q)  out_d[8*c +: 8] = round_sat(prod_q[c]);
      end
    end

    ap_done_d = (state_d == DONE);
    ap_idle_d = (state_d == IDLE);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= IDLE;
      ap_done_q <= 1'b0;
      ap_idle_q <= 1'b1;
      alpha_q   <= '0;
      beta_q    <= '0;
      rd_left_q <= '0;
      wr_left_q <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      diff_q    <= '0;
      prod_q    <= '0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      ap_done_q <= ap_done_d;
      ap_idle_q <= ap_idle_d;
      alpha_q   <= alpha_d;
      beta_q    <= beta_d;
      rd_left_q <= rd_left_d;
      wr_left_q <= wr_left_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      v3_q      <= v3_d;
      diff_q    <= diff_d;
      prod_q    <= prod_d;
      out_q     <= out_d;
    end
  end

endmodule
